// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } state_e;

  // Width of the iteration counter: must hold values 0..nbits.
  function automatic int unsigned cnt_width(input int unsigned nbits);
    return $clog2(nbits + 1);
  endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Request/response handshake bundle for mult_seq.
interface mult_seq_if #(
  parameter int unsigned p_nbits = 32
);
  logic               req_val;
  logic               req_rdy;
  logic               req_signed;
  logic [p_nbits-1:0] req_a;
  logic [p_nbits-1:0] req_b;
  logic               kill;
  logic               resp_val;
  logic               resp_rdy;
  logic [p_nbits-1:0] resp_hi;
  logic [p_nbits-1:0] resp_lo;
  logic               busy;

  modport master (
    output req_val, req_signed, req_a, req_b, kill, resp_rdy,
    input  req_rdy, resp_val, resp_hi, resp_lo, busy
  );

  modport slave (
    input  req_val, req_signed, req_a, req_b, kill, resp_rdy,
    output req_rdy, resp_val, resp_hi, resp_lo, busy
  );
endinterface

// File: rtl/mult_seq_adder.sv
// Plain ripple-style adder with carry in/out, shared by the multiplier datapath.
module mult_seq_adder #(
  parameter int unsigned p_nbits = 32
) (
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  input  logic               cin,
  output logic [p_nbits-1:0] sum,
  output logic               cout
);
  always_comb begin
    {cout, sum} = {1'b0, in0} + {1'b0, in1} + {{p_nbits{1'b0}}, cin};
  end
endmodule

// File: rtl/mult_seq.sv
// Iterative shift-add multiplier (MULT/MULTU): magnitudes are multiplied unsigned,
// then the 2N-bit product is negated in FIX when the operand signs differ.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int unsigned p_nbits = 32
) (
  input logic     clk,
  input logic     rst_n,
  mult_seq_if.slave bus
);
  localparam int unsigned CntW = cnt_width(p_nbits);

  state_e               state_q, state_d;
  logic [p_nbits-1:0]   a_q, a_d;
  logic [p_nbits-1:0]   hi_q, hi_d;
  logic [p_nbits-1:0]   lo_q, lo_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 neg_q, neg_d;

  logic                 accept;
  logic [p_nbits-1:0]   add_in1;
  logic [p_nbits-1:0]   add_sum;
  logic                 add_cout;
  logic [p_nbits-1:0]   a_mag, b_mag;
  logic [2*p_nbits-1:0] prod;

  assign accept = (state_q == StIdle) && bus.req_val && !bus.kill;

  mult_seq_adder #(
    .p_nbits(p_nbits)
  ) u_adder (
    .in0  (hi_q),
    .in1  (add_in1),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StCalc;
      StCalc: begin
        if (bus.kill)                  state_d = StIdle;
        else if (cnt_q == CntW'(1))    state_d = StFix;
      end
      StFix:  state_d = bus.kill ? StIdle : StDone;
      StDone: if (bus.kill || bus.resp_rdy) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    bus.req_rdy  = (state_q == StIdle);
    bus.busy     = (state_q != StIdle);
    bus.resp_val = (state_q == StDone);
    bus.resp_hi  = hi_q;
    bus.resp_lo  = lo_q;
    add_in1      = lo_q[0] ? a_q : '0;
  end

  // Datapath next-state
  always_comb begin
    a_d   = a_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    // Negating as p_nbits-bit values maps the most negative input onto its
    // unsigned magnitude without overflow.
    a_mag = (bus.req_signed && bus.req_a[p_nbits-1]) ? -bus.req_a : bus.req_a;
    b_mag = (bus.req_signed && bus.req_b[p_nbits-1]) ? -bus.req_b : bus.req_b;
    prod  = {hi_q, lo_q};
    case (state_q)
      StIdle: begin
        if (accept) begin
          a_d   = a_mag;
          lo_d  = b_mag;
          hi_d  = '0;
          cnt_d = CntW'(p_nbits);
          neg_d = bus.req_signed & (bus.req_a[p_nbits-1] ^ bus.req_b[p_nbits-1]);
        end
      end
      StCalc: begin
        {hi_d, lo_d} = {add_cout, add_sum, lo_q[p_nbits-1:1]};
        cnt_d        = cnt_q - CntW'(1);
      end
      StFix: begin
        if (neg_q) {hi_d, lo_d} = -prod;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed corner products, kill/reset abort,
// response hold, and randomized operands against a 64-bit arithmetic model.
module tb_mult_seq;
  localparam int unsigned N = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  mult_seq_if #(.p_nbits(N)) bus ();

  mult_seq #(
    .p_nbits(N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: sign/zero extend to 64 bits and multiply; low 64 bits are the product.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [63:0] xa, xb;
    xa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    xb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return xa * xb;
  endfunction

  // Called at a negedge; issues one request, waits for the result, holds it, retires it.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int hold, input logic [63:0] exp, input string tag);
    int   cyc;
    logic seen;
    check({tag, "/req_rdy"}, bus.req_rdy, 1);
    bus.req_val    = 1'b1;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.req_signed = sgn;
    @(posedge clk);
    #1;
    bus.req_val    = 1'b0;
    bus.req_a      = $urandom;
    bus.req_b      = $urandom;
    bus.req_signed = 1'($urandom_range(0, 1));
    // Cycle 1 is the cycle that starts at the accept edge.
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 100 && !seen) begin
      @(negedge clk);
      cyc++;
      seen = bus.resp_val;
    end
    check({tag, "/latency"}, cyc, 34);
    if (seen) begin
      check({tag, "/hi"}, bus.resp_hi, exp[63:32]);
      check({tag, "/lo"}, bus.resp_lo, exp[31:0]);
      check({tag, "/rdy_in_done"}, bus.req_rdy, 0);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "/hold_val"}, bus.resp_val, 1);
        check({tag, "/hold_data"}, {bus.resp_hi, bus.resp_lo}, exp);
      end
      bus.resp_rdy = 1'b1;
      @(negedge clk);
      bus.resp_rdy = 1'b0;
      check({tag, "/idle_rdy"}, bus.req_rdy, 1);
      check({tag, "/idle_val"}, bus.resp_val, 0);
    end
  endtask

  // Counts resp_val cycles over a window; any is a spurious response.
  task automatic watch_quiet(input int cycles, input string tag);
    int hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.resp_val || bus.busy) hits++;
    end
    check(tag, hits, 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    bus.req_val    = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.kill       = 1'b0;
    bus.resp_rdy   = 1'b0;

    repeat (2) @(negedge clk);
    check("rst/req_rdy", bus.req_rdy, 1);
    check("rst/busy", bus.busy, 0);
    check("rst/resp_val", bus.resp_val, 0);
    check("rst/hi", bus.resp_hi, 0);
    check("rst/lo", bus.resp_lo, 0);

    // First request accepted on the very first edge after release.
    rst_n = 1'b1;
    run_op(32'd3, 32'd4, 1'b0, 0, 64'h0000_0000_0000_000C, "u3x4");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 64'hFFFF_FFFE_0000_0001, "uffxff");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 64'h0000_0000_0000_0001, "sffxff");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 64'h4000_0000_0000_0000, "sminxmin");
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 10, 64'hFFFF_FFFF_8000_0000, "smin_hold");

    // Kill during CALC cycle 5.
    bus.req_val = 1'b1;
    bus.req_a   = 32'h1234;
    bus.req_b   = 32'h5678;
    @(posedge clk);
    #1;
    bus.req_val = 1'b0;
    repeat (5) @(negedge clk);
    check("kill/busy_before", bus.busy, 1);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill/busy", bus.busy, 0);
    check("kill/req_rdy", bus.req_rdy, 1);
    // Kill in IDLE blocks acceptance.
    bus.kill    = 1'b1;
    bus.req_val = 1'b1;
    @(negedge clk);
    bus.kill    = 1'b0;
    bus.req_val = 1'b0;
    check("kill_idle/busy", bus.busy, 0);
    watch_quiet(40, "kill/no_resp");
    run_op(32'd7, 32'd6, 1'b0, 0, 64'd42, "after_kill");

    // Asynchronous reset during CALC cycle 10.
    bus.req_val = 1'b1;
    bus.req_a   = 32'h55;
    bus.req_b   = 32'h77;
    @(posedge clk);
    #1;
    bus.req_val = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst/busy", bus.busy, 0);
    check("arst/resp_val", bus.resp_val, 0);
    check("arst/req_rdy", bus.req_rdy, 1);
    check("arst/data", {bus.resp_hi, bus.resp_lo}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet(40, "arst/no_resp");

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = 32'h0;
        2: ra = 32'h7FFF_FFFF;
        default: ;
      endcase
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, int'($urandom_range(0, 2)), model(ra, rb, rs), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 The block SHALL have parameter p_nbits, default 32, giving the operand width; the product width is 2*p_nbits.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_val  input  1  a multiply request is valid.
REQ-005 req_rdy  output  1  the block can accept a request.
REQ-006 req_signed  input  1  1 = MULT (two's complement), 0 = MULTU.
REQ-007 req_a  input  p_nbits  multiplicand.
REQ-008 req_b  input  p_nbits  multiplier.
REQ-009 kill  input  1  synchronous abort of any in-flight operation, for pipeline flush on exception.
REQ-010 resp_val  output  1  the result is valid.
REQ-011 resp_rdy  input  1  the consumer accepts the result.
REQ-012 resp_hi  output  p_nbits  upper half of the product (HI).
REQ-013 resp_lo  output  p_nbits  lower half of the product (LO).
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL implement the states IDLE, CALC, FIX and DONE.
REQ-016 req_rdy SHALL be high only in IDLE; a request SHALL be accepted when req_val and req_rdy are high and kill is low.
REQ-017 On accept, the block SHALL latch |req_a| and |req_b| (the raw values when req_signed=0), set neg = req_signed & (a[msb] ^ b[msb]), load the iteration counter with p_nbits, clear the HI accumulator, load the multiplier into the LO register, and go to CALC.
REQ-018 Operand magnitudes SHALL be treated as p_nbits-bit unsigned values, so -2^(p_nbits-1) SHALL become 2^(p_nbits-1) without overflow.
REQ-019 Each CALC cycle SHALL drive the shared adder with in0 = HI accumulator, in1 = multiplicand if LO[0]=1 and 0 otherwise, and cin = 0.
REQ-020 Each CALC cycle SHALL then shift {cout, sum, LO} right by one into {HI, LO} and decrement the counter.
REQ-021 CALC SHALL last exactly p_nbits cycles, then go to FIX.
REQ-022 FIX SHALL take one cycle: it negates the 2*p_nbits product (two's complement) if neg=1 and passes it unchanged otherwise, then goes to DONE.
REQ-023 resp_val SHALL be high only in DONE, i.e. p_nbits+2 cycles after the accept edge (34 cycles for the default).
REQ-024 resp_hi and resp_lo SHALL hold stable while resp_val=1 and resp_rdy=0.
REQ-025 DONE with resp_rdy=1 SHALL return to IDLE on the next edge, and no request SHALL be accepted in that same cycle.
REQ-026 kill=1 in CALC, FIX or DONE SHALL return the block to IDLE on the next edge; no response SHALL be produced and the result SHALL be discarded.
REQ-027 kill=1 in IDLE SHALL block acceptance even when req_val=1.
REQ-028 The inputs req_a, req_b and req_signed SHALL be ignored outside the accept cycle.

Reset
REQ-029 While rst_n=0, the block SHALL be forced to IDLE.
REQ-030 While rst_n=0, resp_val, busy, resp_hi, resp_lo, the counter, neg and all datapath registers SHALL be 0, and req_rdy SHALL be 1.
REQ-031 Reset asserted mid-operation SHALL abandon the operation immediately, with no response after release.
REQ-032 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-033 The state encoding (IDLE=0, CALC=1, FIX=2, DONE=3) and the counter width constant clog2(p_nbits+1) SHALL live in the shared package mult_seq_pkg.
REQ-034 The block SHALL instantiate exactly one existing adder sub-module with p_nbits width for all CALC accumulation.
REQ-035 The FIX negation SHALL use local logic, not a second adder instance.

Verification
REQ-036 Unsigned 3 x 4 SHALL give resp_val at cycle 34 after accept with hi=0x00000000, lo=0x0000000C.
REQ-037 Unsigned 0xFFFFFFFF x 0xFFFFFFFF SHALL give hi=0xFFFFFFFE, lo=0x00000001; signed 0xFFFFFFFF x 0xFFFFFFFF SHALL give hi=0, lo=1.
REQ-038 Signed 0x80000000 x 0x80000000 SHALL give hi=0x40000000, lo=0; signed 0x80000000 x 1 SHALL give hi=0xFFFFFFFF, lo=0x80000000.
REQ-039 Holding resp_rdy=0 for 10 cycles in DONE SHALL keep resp_val and the data stable; resp_rdy=1 SHALL then lead to IDLE, with req_rdy=1 the next cycle.
REQ-040 kill at CALC cycle 5 SHALL give IDLE next cycle with no resp_val ever; a following request 7 x 6 SHALL return lo=42.
REQ-041 rst_n low at CALC cycle 10 SHALL force IDLE, busy=0 and outputs 0 asynchronously, with no spurious resp_val after release.
